// File: rtl/sub_pkg.sv
// Shared definitions for the serial ripple-borrow subtractor: FSM encoding and
// helpers that derive the slice count and slice-counter width from WIDTH/DIGIT.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_ripple_borrow_subtractor_full_subtractor.sv
// One-bit full subtractor: i_bit1 - i_bit2 - i_borrow, producing difference and borrow-out.
module full_subtractor (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_borrow,
  output logic o_diff,
  output logic o_borrow
);

  assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
  assign o_borrow = (~i_bit1 & i_bit2) | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/serial_ripple_borrow_subtractor.sv
// Multi-cycle unsigned subtractor: DIGIT bits per clock, LSB first, result held until accepted.
// Optional signed-overflow output is compiled in with SUB_SIGNED_OVERFLOW_EN.
module serial_ripple_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_difference,
  output logic             o_borrow
`ifdef SUB_SIGNED_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int N     = calc_n(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $fatal(1, "serial_ripple_borrow_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic             borrow_run_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic [DIGIT:0]   bchain_d;
  logic [DIGIT-1:0] slice_d;
  logic [WIDTH-1:0] work_d;

  // Operands shift right each RUN cycle so the active slice is always bits [DIGIT-1:0].
  assign bchain_d[0] = borrow_run_q;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_chain
      full_subtractor u_fs (
        .i_bit1   (a_q[gi]),
        .i_bit2   (b_q[gi]),
        .i_borrow (bchain_d[gi]),
        .o_diff   (slice_d[gi]),
        .o_borrow (bchain_d[gi+1])
      );
    end
  endgenerate

  // Each new slice enters at the top; after N slices the working register is LSB-aligned.
  assign work_d = (work_q >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));

`ifdef SUB_SIGNED_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
  logic ovf_d;

  assign ovf_d      = (a_msb_q ^ b_msb_q) & (work_d[WIDTH-1] ^ a_msb_q);
  assign o_overflow = ovf_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && i_valid && ready_q) begin
        a_msb_q <= i_minuend[WIDTH-1];
        b_msb_q <= i_subtrahend[WIDTH-1];
      end
      if (state_q == ST_RUN && cnt_q == LAST_SLICE) begin
        ovf_q <= ovf_d;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      borrow_run_q <= 1'b0;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && ready_q) begin
            a_q          <= i_minuend;
            b_q          <= i_subtrahend;
            work_q       <= '0;
            borrow_run_q <= 1'b0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q          <= a_q >> DIGIT;
          b_q          <= b_q >> DIGIT;
          work_q       <= work_d;
          borrow_run_q <= bchain_d[DIGIT];
          cnt_q        <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SLICE) begin
            diff_q   <= work_d;
            borrow_q <= bchain_d[DIGIT];
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_difference = diff_q;
  assign o_borrow     = borrow_q;

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Bench for the serial subtractor: one WIDTH=8/DIGIT=1 and one WIDTH=8/DIGIT=4 instance,
// table vectors, backpressure, mid-operation reset and random traffic with a reference model.
module tb_serial_ripple_borrow_subtractor;

  logic       clk;
  logic       rst_n;
  logic       valid_i [2];
  logic       rdy_o   [2];
  logic [7:0] a_i     [2];
  logic [7:0] b_i     [2];
  logic       vld_o   [2];
  logic       ready_i [2];
  logic [7:0] diff_o  [2];
  logic       bor_o   [2];
`ifdef SUB_SIGNED_OVERFLOW_EN
  logic       ovf_o   [2];
`endif

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_ripple_borrow_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid_i[0]),
    .o_ready      (rdy_o[0]),
    .i_minuend    (a_i[0]),
    .i_subtrahend (b_i[0]),
    .o_valid      (vld_o[0]),
    .i_ready      (ready_i[0]),
    .o_difference (diff_o[0]),
    .o_borrow     (bor_o[0])
`ifdef SUB_SIGNED_OVERFLOW_EN
    ,
    .o_overflow   (ovf_o[0])
`endif
  );

  serial_ripple_borrow_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid_i[1]),
    .o_ready      (rdy_o[1]),
    .i_minuend    (a_i[1]),
    .i_subtrahend (b_i[1]),
    .o_valid      (vld_o[1]),
    .i_ready      (ready_i[1]),
    .o_difference (diff_o[1]),
    .o_borrow     (bor_o[1])
`ifdef SUB_SIGNED_OVERFLOW_EN
    ,
    .o_overflow   (ovf_o[1])
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Full transaction on instance s: offer operands, time the result, check it, hold, release.
  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input int exp_lat, input int gap, input int hold,
                        input bit scramble, input bit early, input string tag);
    int t;
    int lat;
    bit bad;
    repeat (gap) @(negedge clk);
    valid_i[s] = 1'b1;
    a_i[s]     = a;
    b_i[s]     = b;
    t = 0;
    while (!rdy_o[s] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk({tag, " accept_timeout"}, 32'(t), 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid_i[s] = 1'b0;
    if (early) ready_i[s] = 1'b1;
    chk({tag, " ready_low_after_accept"}, 32'(rdy_o[s]), 32'd0);
    lat = 0;
    while (!vld_o[s] && lat < 100) begin
      if (scramble) begin
        a_i[s]     = 8'($urandom);
        b_i[s]     = 8'($urandom);
        valid_i[s] = 1'b1;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    valid_i[s] = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " difference"}, 32'(diff_o[s]), 32'(ed));
    chk({tag, " borrow"}, 32'(bor_o[s]), 32'(eb));
`ifdef SUB_SIGNED_OVERFLOW_EN
    chk({tag, " overflow"}, 32'(ovf_o[s]), 32'(eo));
`else
    if (eo === 1'bx) $display("note: overflow expectation unknown for %s", tag);
`endif
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (vld_o[s] !== 1'b1 || diff_o[s] !== ed || bor_o[s] !== eb) bad = 1'b1;
    end
    if (hold > 0) chk({tag, " hold_stable"}, 32'(bad), 32'd0);
    ready_i[s] = 1'b1;
    @(negedge clk);
    ready_i[s] = 1'b0;
    chk({tag, " ready_after_release"}, 32'(rdy_o[s]), 32'd1);
    chk({tag, " valid_after_release"}, 32'(vld_o[s]), 32'd0);
  endtask

  initial begin
    logic [8:0] full;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       ro;
    bit         early;
    int         hold;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    vecs[9] = '{8'h12, 8'h34, 8'hDE, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      valid_i[s] = 1'b0;
      ready_i[s] = 1'b0;
      a_i[s]     = 8'h00;
      b_i[s]     = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset ready", 32'(rdy_o[s]), 32'd1);
      chk("reset valid", 32'(vld_o[s]), 32'd0);
      chk("reset difference", 32'(diff_o[s]), 32'd0);
      chk("reset borrow", 32'(bor_o[s]), 32'd0);
`ifdef SUB_SIGNED_OVERFLOW_EN
      chk("reset overflow", 32'(ovf_o[s]), 32'd0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf,
             8, 0, 0, 1'b0, 1'b0, $sformatf("vec1_%0d", i));
      run_op(1, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf,
             2, 0, 0, 1'b0, 1'b0, $sformatf("vec4_%0d", i));
    end

    run_op(0, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 8, 1, 5, 1'b1, 1'b0, "backpressure1");
    run_op(1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 2, 1, 5, 1'b1, 1'b0, "backpressure4");

    // Abort a live operation with reset three cycles after the accept edge.
    @(negedge clk);
    valid_i[0] = 1'b1;
    a_i[0]     = 8'h33;
    b_i[0]     = 8'h11;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    rst_n      = 1'b0;
    valid_i[0] = 1'b0;
    #1;
    chk("midreset ready", 32'(rdy_o[0]), 32'd1);
    chk("midreset valid", 32'(vld_o[0]), 32'd0);
    chk("midreset difference", 32'(diff_o[0]), 32'd0);
    chk("midreset borrow", 32'(bor_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("postreset ready", 32'(rdy_o[0]), 32'd1);
    chk("postreset valid", 32'(vld_o[0]), 32'd0);
    run_op(0, 8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 8, 0, 0, 1'b0, 1'b0, "after_reset");

    for (int k = 0; k < 1300; k++) begin
      int s;
      s     = (k < 1000) ? 0 : 1;
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      full  = {1'b0, ra} - {1'b0, rb};
      ro    = (ra[7] ^ rb[7]) & (full[7] ^ ra[7]);
      early = ($urandom_range(0, 3) == 0);
      hold  = early ? 0 : int'($urandom_range(0, 3));
      run_op(s, ra, rb, full[7:0], full[8], ro, (s == 0) ? 8 : 2,
             int'($urandom_range(0, 3)), hold, ($urandom_range(0, 1) == 1), early,
             $sformatf("rand%0d_%0d", s, k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_ripple_borrow_subtractor.md
Name: serial_ripple_borrow_subtractor

Overview:
Multi-cycle unsigned subtractor that computes the difference and borrow-out of two WIDTH-bit operands.
Operands are captured on a valid/ready handshake, then processed LSB-first in DIGIT-bit slices through a ripple-borrow chain, one slice per clock.
Result is held on the output until the consumer accepts it.
Used as the area-lean subtract path alongside the team's ripple-carry adder in datapath blocks.

Parameters:
WIDTH, 8, operand width in bits (>=2)
DIGIT, 1, bits processed per RUN cycle; must divide WIDTH exactly (elaboration-time check, fatal on violation)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operands present on i_minuend/i_subtrahend
o_ready  output  1  block can accept operands
i_minuend  input  WIDTH  operand A
i_subtrahend  input  WIDTH  operand B
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_difference  output  WIDTH  (A - B) mod 2^WIDTH
o_borrow  output  1  1 when A < B unsigned

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE, slice counter 0, internal borrow 0, operand and result registers 0. o_ready=1, o_valid=0, o_difference=0, o_borrow=0 (o_overflow=0 when compiled in).
- States: IDLE, RUN, DONE. 2-bit encoding, no other states reachable.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: capture A and B, clear the borrow, set counter to 0, go to RUN.
- RUN:
  - o_ready=0, o_valid=0.
  - Each cycle computes slice k (bits k*DIGIT .. k*DIGIT+DIGIT-1) through DIGIT chained full-subtractors, borrow-in = registered borrow.
  - Writes the slice into the result register, registers the borrow-out and increments the counter.
  - After slice N-1 (N=WIDTH/DIGIT), go to DONE.
- DONE:
  - o_valid=1; o_difference and o_borrow stable and equal to the final values.
  - On i_ready, go to IDLE.
  - If i_ready is low, hold indefinitely with outputs unchanged.
- Latency:
  - Handshake accepted at edge E. o_valid is high in the cycle after edge E+N, i.e. N cycles after the accept edge.
  - Minimum issue interval is N+2 cycles. There is no back-to-back accept, because o_ready is low in RUN and DONE.
- Operand inputs are ignored outside the accept cycle; changes during RUN or DONE have no effect.
- i_valid while o_ready=0 is ignored. The producer must hold it until accepted.
- i_ready while o_valid=0 is ignored.
- o_difference updates only when leaving RUN, so partial slices are never visible on the output. A result register that is distinct from the working register is required.
- Arithmetic: {o_borrow, o_difference} equals the WIDTH+1-bit two's-complement of A-B, with o_borrow being the borrow out of the MSB.
- Wrap-around: 0 - 1 gives difference all-ones, borrow 1. A - A gives 0, borrow 0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. After release the block is in IDLE with reset values and no stale o_valid.

Optional Feature:
- Macro: SUB_SIGNED_OVERFLOW_EN.
- Defined:
  - Adds output port o_overflow (1 bit), valid with o_valid.
  - o_overflow=1 when A and B have different MSBs and the difference MSB differs from A's MSB (signed overflow).
  - Reset value 0, held in DONE like o_difference.
- Undefined: no port and no logic; interface is exactly as listed.

Decomposition:
- Shared package sub_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a function computing N=WIDTH/DIGIT and the counter width clog2(N) (minimum 1).
- One natural sub-module: full_subtractor (i_bit1, i_bit2, i_borrow -> o_diff, o_borrow), instantiated DIGIT times in a generate loop for the slice chain.

Test Plan:
- WIDTH=8, DIGIT=1: A=0x05, B=0x03, i_ready=1 -> o_valid exactly 8 cycles after accept; difference 0x02, borrow 0; o_ready high the cycle after the result is accepted.
- A=0x03, B=0x05 -> difference 0xFE, borrow 1. A=0x00, B=0x01 -> 0xFF, borrow 1. A=0xA5, B=0xA5 -> 0x00, borrow 0.
- Backpressure: A=0x10, B=0x01 with i_ready low for 5 cycles -> o_valid and difference 0x0F held stable all 5 cycles; inputs toggled during RUN do not alter the result.
- Reset mid-op: assert i_rst_n low 3 cycles after accept -> outputs go to reset values asynchronously (before the next edge); after release o_ready=1, o_valid=0; the next op A=0x09, B=0x04 gives 0x05.
- WIDTH=8, DIGIT=4: A=0x80, B=0x01 -> o_valid 2 cycles after accept, difference 0x7F, borrow 0; with SUB_SIGNED_OVERFLOW_EN, o_overflow=1. Compare against A=0x7F, B=0xFF -> 0x80, borrow 1, o_overflow=1.
- Random: 1000 operand pairs per (WIDTH, DIGIT) in {(8,1), (8,2), (16,4), (32,8)} with random i_valid/i_ready gaps -> scoreboard matches the reference model A-B exactly; no accept while o_ready=0.
